// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute/writeback sequencer for picoMIPS.
// Fetches over a req/valid handshake, decodes the IR, writes back ALU results and steers pc.
`default_nettype none

module instr_sequencer #(
    parameter int  REG_WIDTH   = 8,
    parameter int  IMM_WIDTH   = 8,
    parameter int  RADDR_WIDTH = 2,
    parameter int  PC_WIDTH    = 8,
    localparam int INSTR_WIDTH = 1 + 2 * RADDR_WIDTH + IMM_WIDTH
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   start,
    output logic                   prog_req,
    output logic [PC_WIDTH-1:0]    prog_addr,
    input  logic                   prog_valid,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic                   op_code,
    output logic [IMM_WIDTH-1:0]   immediate,
    output logic [RADDR_WIDTH-1:0] rd_addr_1,
    output logic [RADDR_WIDTH-1:0] rd_addr_2,
    input  logic                   branch,
    input  logic [REG_WIDTH-1:0]   wr_data,
    output logic                   wr_en,
    output logic [RADDR_WIDTH-1:0] wr_addr,
    output logic [REG_WIDTH-1:0]   wr_data_q,
    output logic                   halted,
    output logic [15:0]            retired
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic                   branch_q;
    logic [REG_WIDTH-1:0]   wr_data_qq;
    logic [15:0]            retired_q;
    logic                   prog_req_q;
    logic                   wr_en_q;
    logic                   halted_q;

    logic                   ir_op;
    logic [RADDR_WIDTH-1:0] ir_ra;
    logic [RADDR_WIDTH-1:0] ir_rb;
    logic [IMM_WIDTH-1:0]   ir_imm;
    logic [PC_WIDTH-1:0]    target;
    logic [PC_WIDTH-1:0]    pc_d;
    logic [15:0]            retired_d;
    logic                   halt_d;

    assign ir_op  = ir_q[INSTR_WIDTH-1];
    assign ir_ra  = ir_q[INSTR_WIDTH-2 -: RADDR_WIDTH];
    assign ir_rb  = ir_q[INSTR_WIDTH-2-RADDR_WIDTH -: RADDR_WIDTH];
    assign ir_imm = ir_q[IMM_WIDTH-1:0];
    assign target = ir_imm[PC_WIDTH-1:0];

    // A taken branch whose target is its own address is the program's halt idiom.
    assign pc_d      = branch_q ? target : pc_q + 1'b1;
    assign halt_d    = branch_q && (target == pc_q);
    assign retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            branch_q   <= 1'b0;
            wr_data_qq <= '0;
            retired_q  <= '0;
            prog_req_q <= 1'b0;
            wr_en_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_FETCH;
                        prog_req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (prog_valid) begin
                        ir_q       <= prog_data;
                        prog_req_q <= 1'b0;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    branch_q   <= branch & ~ir_op;
                    wr_data_qq <= wr_data;
                    wr_en_q    <= 1'b1;
                    state_q    <= S_WB;
                end
                S_WB: begin
                    wr_en_q   <= 1'b0;
                    pc_q      <= pc_d;
                    retired_q <= retired_d;
                    if (halt_d) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        prog_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q    <= S_IDLE;
                    prog_req_q <= 1'b0;
                    wr_en_q    <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign prog_req  = prog_req_q;
    assign prog_addr = pc_q;
    assign op_code   = ir_op;
    assign immediate = ir_imm;
    assign rd_addr_1 = ir_ra;
    assign rd_addr_2 = ir_rb;
    assign wr_addr   = ir_ra;
    assign wr_en     = wr_en_q;
    assign wr_data_q = wr_data_qq;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed plus randomized checks of instr_sequencer against a pc/retire model.
`default_nettype none

module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start;
    logic        prog_req;
    logic [7:0]  prog_addr;
    logic        prog_valid;
    logic [12:0] prog_data;
    logic        op_code;
    logic [7:0]  immediate;
    logic [1:0]  rd_addr_1;
    logic [1:0]  rd_addr_2;
    logic        branch;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data_q;
    logic        halted;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  pc_m;
    logic [15:0] ret_m;

    instr_sequencer dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .start      (start),
        .prog_req   (prog_req),
        .prog_addr  (prog_addr),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .op_code    (op_code),
        .immediate  (immediate),
        .rd_addr_1  (rd_addr_1),
        .rd_addr_2  (rd_addr_2),
        .branch     (branch),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data_q  (wr_data_q),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Acts as program memory and ALU for one instruction; entered with the DUT in FETCH.
    task automatic run_instr(input logic op, input logic [1:0] ra, input logic [1:0] rb,
                             input logic [7:0] imm, input int stall,
                             input logic [7:0] wd, input logic br);
        logic       taken;
        logic       halt_e;
        check("fetch_req", prog_req, 1);
        check("fetch_addr", prog_addr, pc_m);
        for (int s = 0; s < stall; s++) begin
            prog_valid = 1'b0;
            prog_data  = 13'($urandom);
            tick();
            check("stall_req", prog_req, 1);
            check("stall_addr", prog_addr, pc_m);
            check("stall_wr_en", wr_en, 0);
        end
        prog_valid = 1'b1;
        prog_data  = {op, ra, rb, imm};
        tick();
        prog_valid = 1'b0;
        prog_data  = 13'($urandom);
        check("exec_op", op_code, op);
        check("exec_imm", immediate, imm);
        check("exec_ra", rd_addr_1, ra);
        check("exec_rb", rd_addr_2, rb);
        check("exec_req", prog_req, 0);
        check("exec_wr_en", wr_en, 0);
        branch  = br;
        wr_data = wd;
        tick();
        branch  = 1'($urandom);
        wr_data = 8'($urandom);
        check("wb_wr_en", wr_en, 1);
        check("wb_wr_addr", wr_addr, ra);
        check("wb_wr_data", wr_data_q, wd);
        check("wb_req", prog_req, 0);
        taken  = br && (op == 1'b0);
        halt_e = taken && (imm == pc_m);
        pc_m   = taken ? imm : pc_m + 8'd1;
        if (ret_m != 16'hFFFF) ret_m = ret_m + 16'd1;
        tick();
        check("post_wr_en", wr_en, 0);
        check("post_retired", retired, ret_m);
        check("post_halted", halted, halt_e);
        check("post_req", prog_req, !halt_e);
        if (!halt_e) check("post_addr", prog_addr, pc_m);
    endtask

    initial begin
        logic       r_op;
        logic       r_br;
        logic [7:0] r_imm;

        n_reset    = 1'b0;
        start      = 1'b0;
        prog_valid = 1'b0;
        prog_data  = '0;
        branch     = 1'b0;
        wr_data    = '0;
        pc_m       = 8'h00;
        ret_m      = 16'h0000;

        // Reset and idle with stray prog_valid, which must be ignored
        repeat (3) tick();
        n_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            prog_valid = 1'($urandom);
            tick();
            check("idle_req", prog_req, 0);
        end
        prog_valid = 1'b0;
        check("idle_wr_en", wr_en, 0);
        check("idle_halted", halted, 0);
        check("idle_retired", retired, 0);
        check("idle_addr", prog_addr, 8'h00);

        do_start();
        // MULTI with branch high: branch masked
        run_instr(1'b1, 2'd2, 2'd1, 8'h05, 0, 8'h0F, 1'b1);
        // SUBLEQ taken to 0x40, then not taken
        run_instr(1'b0, 2'd1, 2'd3, 8'h40, 0, 8'hA5, 1'b1);
        run_instr(1'b0, 2'd1, 2'd3, 8'h40, 0, 8'h3C, 1'b0);
        // Memory stall of 4 cycles
        run_instr(1'b0, 2'd0, 2'd2, 8'h10, 4, 8'h77, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_op  = 1'($urandom);
            r_br  = 1'($urandom);
            r_imm = 8'($urandom);
            if (!r_op && r_br && r_imm == pc_m) r_imm = pc_m + 8'd1;
            run_instr(r_op, 2'($urandom), 2'($urandom), r_imm,
                      int'($urandom_range(0, 3)), 8'($urandom), r_br);
        end

        // Jump to 0xFF, wrap to 0x00, then halt on a self-loop at 0x00
        if (pc_m != 8'hFF) run_instr(1'b0, 2'd3, 2'd0, 8'hFF, 1, 8'h11, 1'b1);
        run_instr(1'b0, 2'd2, 2'd1, 8'h33, 0, 8'h22, 1'b0);
        check("wrap_pc", prog_addr, 8'h00);
        run_instr(1'b0, 2'd1, 2'd2, 8'h00, 2, 8'h99, 1'b1);
        for (int i = 0; i < 20; i++) begin
            start      = 1'($urandom);
            prog_valid = 1'($urandom);
            tick();
            check("halt_halted", halted, 1);
            check("halt_req", prog_req, 0);
            check("halt_wr_en", wr_en, 0);
        end
        start      = 1'b0;
        prog_valid = 1'b0;

        // Reset out of HALT, start, then reset mid-fetch
        n_reset = 1'b0;
        tick();
        check("rst_halted", halted, 0);
        n_reset = 1'b1;
        do_start();
        check("refetch_req", prog_req, 1);
        #2;
        n_reset = 1'b0;
        #1;
        check("midrst_req", prog_req, 0);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_halted", halted, 0);
        check("midrst_retired", retired, 0);
        check("midrst_addr", prog_addr, 8'h00);
        prog_valid = 1'b1;
        tick();
        n_reset = 1'b1;
        tick();
        check("after_rst_req", prog_req, 0);
        prog_valid = 1'b0;

        pc_m  = 8'h00;
        ret_m = 16'h0000;
        do_start();
        run_instr(1'b1, 2'd3, 2'd3, 8'hC8, 1, 8'h5A, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
